// File: rtl/meas_code_lock_pkg.sv
// Shared types for the measurement-gated code lock: FSM states and compare codes.
package meas_code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/meas_code_lock_cmp.sv
// Registered unsigned MEAS/REF comparator; the result gates code entry one cycle later.
module meas_cmp
    import meas_code_lock_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] MEAS,
    input  logic [W-1:0] REF,
    output logic [1:0]   COMP
);

    cmp_e comp_q, comp_d;

    // Classify MEAS against REF for the next register load.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves comp_d unassigned (no latch).
        comp_d = CMP_EQ;
        if (MEAS > REF)
            comp_d = CMP_GT;
        else if (MEAS < REF)
            comp_d = CMP_LT;
    end

    // Compare register with synchronous reset to "equal".
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (RST)
            comp_q <= CMP_EQ;
        else
            comp_q <= comp_d;
    end

    assign COMP = comp_q;

endmodule

// File: rtl/meas_code_lock.sv
// Code lock: digits are accepted only while MEAS==REF; a full correct code opens the
// lock for a timed window (during which the secret may be reprogrammed), repeated
// failures trigger a timed lockout.
module meas_code_lock
    import meas_code_lock_pkg::*;
#(
    parameter int                    W           = 4,
    parameter int                    N_DIGITS    = 2,
    parameter logic [N_DIGITS*W-1:0] SECRET_INIT = 8'h1F,
    parameter int                    MAX_TRIES   = 3,
    parameter int                    OPEN_CYCLES = 8,
    parameter int                    LOCK_CYCLES = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [W-1:0]                   MEAS,
    input  logic [W-1:0]                   REF,
    input  logic [W-1:0]                   DIG,
    input  logic                           DIG_VLD,
    input  logic                           PROG,
    output logic [1:0]                     COMP,
    output logic                           CORR,
    output logic                           ERR,
    output logic                           OPEN,
    output logic                           LOCKED,
    output logic [$clog2(MAX_TRIES+1)-1:0] TRIES
);

    localparam int SW  = N_DIGITS * W;
    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int TW  = $clog2(max_int(OPEN_CYCLES, LOCK_CYCLES) + 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [SW-1:0]    secret_q, secret_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [IW-1:0]    pcnt_q, pcnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TRW-1:0]   tries_q, tries_d;
    logic             corr_q, corr_d;
    logic             err_q, err_d;
    logic [W-1:0]     exp_dig;
    logic             mis_now;

    meas_cmp #(.W(W)) u_cmp (
        .CLK  (CLK),
        .RST  (RST),
        .MEAS (MEAS),
        .REF  (REF),
        .COMP (COMP)
    );

    // Select the secret digit expected at the current entry index (first digit = MSBs).
    always_comb begin
        exp_dig = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (idx_q == IW'(i))
                exp_dig = secret_q[(N_DIGITS-1-i)*W +: W];
    end

    // Next-state and datapath decisions for ENTRY / OPEN / LOCKOUT.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        secret_d = secret_q;
        stage_d  = stage_q;
        pcnt_d   = pcnt_q;
        timer_d  = timer_q;
        tries_d  = tries_q;
        corr_d   = 1'b0;
        err_d    = 1'b0;
        mis_now  = mis_q | (DIG != exp_dig);

        unique case (state_q)
            ST_ENTRY: begin
                if (DIG_VLD && COMP == CMP_EQ) begin
                    if (idx_q == IW'(N_DIGITS - 1)) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (mis_now) begin
                            err_d   = 1'b1;
                            tries_d = tries_q + TRW'(1);
                            if (tries_d == TRW'(MAX_TRIES)) begin
                                state_d = ST_LOCKOUT;
                                timer_d = TW'(LOCK_CYCLES);
                            end
                        end else begin
                            corr_d  = 1'b1;
                            tries_d = '0;
                            state_d = ST_OPEN;
                            timer_d = TW'(OPEN_CYCLES);
                            stage_d = '0;
                            pcnt_d  = '0;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                        mis_d = mis_now;
                    end
                end
            end

            ST_OPEN: begin
                if (timer_q != '0)
                    timer_d = timer_q - TW'(1);
                if (DIG_VLD && PROG && pcnt_q == IW'(N_DIGITS - 1)) begin
                    // Final programming digit: commit the whole secret at once, close early.
                    secret_d = (stage_q << W) | SW'(DIG);
                    stage_d  = '0;
                    pcnt_d   = '0;
                    timer_d  = '0;
                    state_d  = ST_ENTRY;
                end else if (timer_q <= TW'(1)) begin
                    // Window expired: any partial programming is discarded.
                    stage_d = '0;
                    pcnt_d  = '0;
                    timer_d = '0;
                    state_d = ST_ENTRY;
                end else if (DIG_VLD && PROG) begin
                    stage_d = (stage_q << W) | SW'(DIG);
                    pcnt_d  = pcnt_q + IW'(1);
                end
            end

            ST_LOCKOUT: begin
                if (timer_q <= TW'(1)) begin
                    timer_d = '0;
                    tries_d = '0;
                    state_d = ST_ENTRY;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: state_d = ST_ENTRY;
        endcase
    end

    // Lock state, counters, secret and staging registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_ENTRY;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            // NOTE: the secret is a plain register, not a memory, so it must be reset to restore SECRET_INIT.
            secret_q <= SECRET_INIT;
            stage_q  <= '0;
            pcnt_q   <= '0;
            timer_q  <= '0;
            tries_q  <= '0;
            corr_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            secret_q <= secret_d;
            stage_q  <= stage_d;
            pcnt_q   <= pcnt_d;
            timer_q  <= timer_d;
            tries_q  <= tries_d;
            corr_q   <= corr_d;
            err_q    <= err_d;
        end
    end

    assign CORR   = corr_q;
    assign ERR    = err_q;
    assign OPEN   = (state_q == ST_OPEN);
    assign LOCKED = (state_q == ST_LOCKOUT);
    assign TRIES  = tries_q;

endmodule

// File: tb/tb_meas_code_lock.sv
// Directed bench for meas_code_lock with hand-computed expectations.
module tb_meas_code_lock;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] MEAS = '0;
    logic [3:0] REF = '0;
    logic [3:0] DIG = '0;
    logic       DIG_VLD = 1'b0;
    logic       PROG = 1'b0;
    logic [1:0] COMP;
    logic       CORR;
    logic       ERR;
    logic       OPEN;
    logic       LOCKED;
    logic [1:0] TRIES;

    int n_vec = 0;
    int n_err = 0;

    meas_code_lock dut (
        .CLK     (CLK),
        .RST     (RST),
        .MEAS    (MEAS),
        .REF     (REF),
        .DIG     (DIG),
        .DIG_VLD (DIG_VLD),
        .PROG    (PROG),
        .COMP    (COMP),
        .CORR    (CORR),
        .ERR     (ERR),
        .OPEN    (OPEN),
        .LOCKED  (LOCKED),
        .TRIES   (TRIES)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic p);
        DIG = d; DIG_VLD = 1'b1; PROG = p;
        tick();
        DIG_VLD = 1'b0; PROG = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, ".corr"},   CORR,   0);
        check_vec({tag, ".err"},    ERR,    0);
        check_vec({tag, ".open"},   OPEN,   0);
        check_vec({tag, ".locked"}, LOCKED, 0);
        check_vec({tag, ".tries"},  TRIES,  0);
    endtask

    initial begin
        // 1: reset (with MEAS>REF so COMP reset is observable), then correct code 1,F
        MEAS = 4'd3; REF = 4'd0;
        tick(); tick();
        check_idle("rst");
        check_vec("rst.comp", COMP, 2'b00);
        RST = 1'b0;
        MEAS = 4'd3; REF = 4'd3;
        tick();
        check_vec("t1.comp", COMP, 2'b00);
        send(4'h1, 1'b0);
        check_idle("t1.d1");
        send(4'hF, 1'b0);
        check_vec("t1.corr", CORR, 1);
        check_vec("t1.open", OPEN, 1);
        check_vec("t1.tries", TRIES, 0);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check_vec($sformatf("t1.open%0d", i), OPEN, 1);
            check_vec($sformatf("t1.corr%0d", i), CORR, 0);
        end
        tick();
        check_vec("t1.open_end", OPEN, 0);

        // 2: gate closed for MEAS>REF and MEAS<REF
        MEAS = 4'd3; REF = 4'd0;
        tick();
        check_vec("t2.comp_gt", COMP, 2'b01);
        send(4'h1, 1'b0); check_idle("t2.gt1");
        send(4'hF, 1'b0); check_idle("t2.gtF");
        MEAS = 4'd0; REF = 4'd3;
        tick();
        check_vec("t2.comp_lt", COMP, 2'b10);
        send(4'h1, 1'b0); check_idle("t2.lt1");
        send(4'hF, 1'b0); check_idle("t2.ltF");

        // 3: three wrong codes -> lockout for 16 cycles, digits ignored, then reopen
        MEAS = 4'd5; REF = 4'd5;
        tick();
        for (int k = 1; k <= 3; k++) begin
            send(4'h1, 1'b0);
            check_vec($sformatf("t3.err_d1_%0d", k), ERR, 0);
            send(4'hE, 1'b0);
            check_vec($sformatf("t3.err_%0d", k), ERR, 1);
            check_vec($sformatf("t3.tries_%0d", k), TRIES, k);
            check_vec($sformatf("t3.corr_%0d", k), CORR, 0);
            check_vec($sformatf("t3.locked_%0d", k), LOCKED, (k == 3));
            if (k < 3) begin
                tick();
                check_vec($sformatf("t3.errclr_%0d", k), ERR, 0);
            end
        end
        for (int i = 2; i <= 16; i++) begin
            if (i == 3)      send(4'h1, 1'b0);
            else if (i == 4) send(4'hF, 1'b0);
            else             tick();
            check_vec($sformatf("t3.locked%0d", i), LOCKED, 1);
            check_vec($sformatf("t3.open%0d", i), OPEN, 0);
            check_vec($sformatf("t3.tries%0d", i), TRIES, 3);
        end
        tick();
        check_vec("t3.locked_end", LOCKED, 0);
        check_vec("t3.tries_end", TRIES, 0);
        send(4'h1, 1'b0);
        send(4'hF, 1'b0);
        check_vec("t3.reopen_corr", CORR, 1);
        check_vec("t3.reopen_open", OPEN, 1);

        // 4: reprogram secret to A5 while open
        send(4'hA, 1'b1);
        check_vec("t4.open_mid", OPEN, 1);
        send(4'h5, 1'b1);
        check_vec("t4.open_drop", OPEN, 0);
        send(4'h1, 1'b0);
        send(4'hF, 1'b0);
        check_vec("t4.old_err", ERR, 1);
        check_vec("t4.old_tries", TRIES, 1);
        check_vec("t4.old_open", OPEN, 0);
        send(4'hA, 1'b0);
        send(4'h5, 1'b0);
        check_vec("t4.new_corr", CORR, 1);
        check_vec("t4.new_open", OPEN, 1);
        check_vec("t4.new_tries", TRIES, 0);

        // 6a: reset while open after reprogramming; secret returns to 1F
        MEAS = 4'd7; REF = 4'd2;
        RST = 1'b1;
        tick();
        check_idle("t6a");
        check_vec("t6a.comp", COMP, 2'b00);
        RST = 1'b0;
        MEAS = 4'd5; REF = 4'd5;
        tick();
        send(4'h1, 1'b0);
        send(4'hF, 1'b0);
        check_vec("t6a.corr_1F", CORR, 1);
        check_vec("t6a.open_1F", OPEN, 1);

        // 5: partial programming then timer expiry; secret unchanged
        send(4'hA, 1'b1);
        check_vec("t5.open2", OPEN, 1);
        for (int i = 3; i <= 8; i++) begin
            tick();
            check_vec($sformatf("t5.open%0d", i), OPEN, 1);
        end
        tick();
        check_vec("t5.open_end", OPEN, 0);
        send(4'h1, 1'b0);
        send(4'hF, 1'b0);
        check_vec("t5.corr_1F", CORR, 1);
        check_vec("t5.open_1F", OPEN, 1);
        for (int i = 2; i <= 9; i++) tick();
        check_vec("t5.closed", OPEN, 0);

        // 6b: reset during lockout
        for (int k = 1; k <= 3; k++) begin
            send(4'h1, 1'b0);
            send(4'hE, 1'b0);
            if (k < 3) tick();
        end
        check_vec("t6b.locked", LOCKED, 1);
        tick(); tick(); tick();
        check_vec("t6b.locked_mid", LOCKED, 1);
        RST = 1'b1;
        tick();
        check_idle("t6b");
        RST = 1'b0;
        tick();
        send(4'h1, 1'b0);
        send(4'hF, 1'b0);
        check_vec("t6b.corr", CORR, 1);
        check_vec("t6b.open", OPEN, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
